// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: register word offsets, CTRL/STATUS bit positions and ID constant for apb_timer
package apb_timer_pkg;
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LOAD   = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_ID     = 3'd4;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_AUTO     = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_PS_LSB   = 8;
  localparam int STATUS_EXPIRED = 0;
  localparam logic [31:0] TIMER_ID = 32'hA7B0_0001;
endpackage

// File: rtl/apb_timer_prescaler.sv
// apb_timer_prescaler: 8-bit divider, ticks once every prescale+1 enabled cycles
module apb_timer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] prescale,
  output logic       tick
);
  logic [7:0] cnt;
  assign tick = en && cnt == prescale;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? 8'd0 : cnt + 8'd1;
endmodule

// File: rtl/apb_timer.sv
// apb_timer: APB down-counting timer with one-shot/auto-reload and W1C expiry interrupt.
// Optional prescaler enabled by defining APB_TIMER_PRESCALER_EN.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  irq
);
  logic pend, wr_q, en, auto, irq_en, expired, tick, fire;
  logic wr_ctrl, wr_load, wr_status;
  logic [2:0] addr_q;
  logic [31:0] wdata_q, load, count, rd_val;
  logic [7:0] prescale;
  logic unused_addr;
  assign unused_addr = ^{paddr[ADDR_WIDTH-1:5], paddr[1:0]};
  assign wr_ctrl   = penable && pend && wr_q && addr_q == OFF_CTRL;
  assign wr_load   = penable && pend && wr_q && addr_q == OFF_LOAD;
  assign wr_status = penable && pend && wr_q && addr_q == OFF_STATUS;
  // a LOAD write cancels any tick landing in the same cycle
  assign fire = tick && !wr_load;
`ifdef APB_TIMER_PRESCALER_EN
  logic ps_clr;
  assign ps_clr = wr_load || (wr_ctrl && !en && wdata_q[CTRL_EN]);
  apb_timer_prescaler u_prescaler (
    .clk(hclk), .rst(hreset), .en(en), .clr(ps_clr), .prescale(prescale), .tick(tick)
  );
  always_ff @(posedge hclk or posedge hreset)
    if (hreset) prescale <= '0;
    else if (wr_ctrl) prescale <= wdata_q[CTRL_PS_LSB +: 8];
`else
  assign prescale = 8'd0;
  assign tick = en;
`endif
  always_comb begin
    rd_val = paddr[4:2] == OFF_CTRL   ? {16'b0, prescale, 5'b0, irq_en, auto, en} :
             paddr[4:2] == OFF_LOAD   ? load :
             paddr[4:2] == OFF_COUNT  ? count :
             paddr[4:2] == OFF_STATUS ? {31'b0, expired} :
             paddr[4:2] == OFF_ID     ? TIMER_ID : 32'b0;
  end
  always_ff @(posedge hclk or posedge hreset)
    if (hreset) begin
      pend <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      prdata <= '0;
      en <= 1'b0;
      auto <= 1'b0;
      irq_en <= 1'b0;
      load <= '0;
      count <= '0;
      expired <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (psel && !penable) begin
        addr_q <= paddr[4:2];
        wr_q <= pwrite;
        wdata_q <= pwdata;
        pend <= 1'b1;
        if (!pwrite) prdata <= rd_val;
      end else if (penable) pend <= 1'b0;
      if (wr_ctrl) begin
        en <= wdata_q[CTRL_EN];
        auto <= wdata_q[CTRL_AUTO];
        irq_en <= wdata_q[CTRL_IRQ_EN];
      end else if (fire && count == 0 && !auto) en <= 1'b0;
      if (wr_load) begin
        load <= wdata_q;
        count <= wdata_q;
      end else if (fire) count <= count != 0 ? count - 32'd1 : auto ? load : 32'd0;
      // a new expiry wins over a W1C arriving in the same cycle
      if (fire && count == 0) expired <= 1'b1;
      else if (wr_status && wdata_q[STATUS_EXPIRED]) expired <= 1'b0;
      irq <= expired && irq_en;
    end
endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: randomized scenarios against an arithmetic timer model plus directed edge cases
module tb_apb_timer;
  logic hclk = 1'b0, hreset = 1'b1, psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0, prdata;
  logic irq;
  int total = 0, bad = 0, edge_cnt = 0;
`ifdef APB_TIMER_PRESCALER_EN
  localparam bit PS_ON = 1'b1;
`else
  localparam bit PS_ON = 1'b0;
`endif

  apb_timer dut (
    .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .irq(irq)
  );

  always #5 hclk = ~hclk;
  always @(posedge hclk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // all bus tasks start and end at a falling edge; c is the commit edge index
  task automatic wr(input logic [31:0] a, input logic [31:0] d, output int c);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    c = edge_cnt + 2;
    @(negedge hclk);
    penable = 1'b1;
    @(negedge hclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // s is the setup edge index; d and i are sampled mid access cycle
  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic i, output int s);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    s = edge_cnt + 1;
    @(negedge hclk);
    d = prdata; i = irq;
    penable = 1'b1;
    @(negedge hclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  // state after k clock edges past an enabling CTRL commit, from tick count arithmetic
  function automatic void model(input int k, input int ld, input int p, input bit au,
                                output int cnt, output bit ex, output bit en);
    int n;
    n = k / p;
    if (au) begin
      cnt = ld - (n % (ld + 1)); ex = n >= ld + 1; en = 1'b1;
    end else if (n <= ld) begin
      cnt = ld - n; ex = 1'b0; en = 1'b1;
    end else begin
      cnt = 0; ex = 1'b1; en = 1'b0;
    end
  endfunction

  initial begin
    logic [31:0] d;
    logic i;
    int c, s, a;
    repeat (2) @(negedge hclk);
    hreset = 1'b0;
    @(negedge hclk);
    chk("rst_irq", {31'b0, irq}, 0);
    rd(32'h10, d, i, s); chk("rst_id", d, 32'hA7B0_0001);
    rd(32'h00, d, i, s); chk("rst_ctrl", d, 0);
    rd(32'h04, d, i, s); chk("rst_load", d, 0);
    rd(32'h08, d, i, s); chk("rst_count", d, 0);
    rd(32'h0C, d, i, s); chk("rst_status", d, 0);
    wr(32'h04, 3, c);
    wr(32'h0C, 1, c);
    wr(32'h00, 32'h05, c);
    repeat (2) @(negedge hclk);
    wr(32'h0C, 1, a);
    chk("w1c_edge", a, c + 4);
    rd(32'h0C, d, i, s); chk("w1c_race_status", d, 1); chk("oneshot_irq", {31'b0, i}, 1);
    rd(32'h08, d, i, s); chk("oneshot_count", d, 0);
    rd(32'h00, d, i, s); chk("oneshot_ctrl", d, 32'h04);
    wr(32'h0C, 1, a);
    chk("irq_lag", {31'b0, irq}, 1);
    @(negedge hclk);
    chk("irq_clear", {31'b0, irq}, 0);
    rd(32'h0C, d, i, s); chk("w1c_status", d, 0);
    wr(32'h04, 7, c);
    wr(32'h08, 32'h1234, c);
    wr(32'h18, 32'hFFFF_FFFF, c);
    wr(32'h10, 0, c);
    rd(32'h08, d, i, s); chk("ro_count", d, 7);
    rd(32'h04, d, i, s); chk("ro_load", d, 7);
    rd(32'h18, d, i, s); chk("unmapped", d, 0);
    rd(32'h10, d, i, s); chk("ro_id", d, 32'hA7B0_0001);
    for (int it = 0; it < 24; it++) begin
      int ld, ps, p, idle, cnt;
      bit au, ie, ex, en;
      ld = $urandom_range(0, 6); ps = $urandom_range(0, 3);
      au = 1'($urandom_range(0, 1)); ie = 1'($urandom_range(0, 1));
      idle = $urandom_range(0, 30);
      p = PS_ON ? ps + 1 : 1;
      wr(32'h00, 0, c);
      wr(32'h04, ld, c);
      wr(32'h0C, 1, c);
      wr(32'h00, (ps << 8) | (ie << 2) | (au << 1) | 1, c);
      repeat (idle) @(negedge hclk);
      rd(32'h08, d, i, s);
      model(s - 1 - c, ld, p, au, cnt, ex, en);
      chk("rnd_count", d, cnt);
      chk("rnd_irq", {31'b0, i}, {31'b0, ie & ex});
      rd(32'h0C, d, i, s);
      model(s - 1 - c, ld, p, au, cnt, ex, en);
      chk("rnd_status", d, {31'b0, ex});
      rd(32'h00, d, i, s);
      model(s - 1 - c, ld, p, au, cnt, ex, en);
      chk("rnd_ctrl", d, ((PS_ON ? ps : 0) << 8) | (ie << 2) | (au << 1) | en);
    end
    wr(32'h04, 9, c);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h55;
    @(negedge hclk);
    hreset = 1'b1;
    #1 hreset = 1'b0;
    penable = 1'b1;
    @(negedge hclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rd(32'h04, d, i, s); chk("rst_mid_load", d, 0); chk("rst_mid_irq", {31'b0, i}, 0);
    rd(32'h00, d, i, s); chk("rst_mid_ctrl", d, 0);
    rd(32'h08, d, i, s); chk("rst_mid_count", d, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_timer.md
APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, 32, APB data width; only 32 supported.
REQ-003 SHALL have port hclk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port hreset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port psel  input  1  APB select.
REQ-006 SHALL have port penable  input  1  APB access phase.
REQ-007 SHALL have port pwrite  input  1  1 = write.
REQ-008 SHALL have port paddr  input  ADDR_WIDTH  byte address; paddr[4:2] decoded, rest ignored.
REQ-009 SHALL have port pwdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port prdata  output  DATA_WIDTH  registered read data.
REQ-011 SHALL have port irq  output  1  registered interrupt, EXPIRED & IRQ_EN.

Function
REQ-012 Setup phase (psel=1, penable=0) SHALL latch paddr, pwrite, pwdata and set internal pend=1.
REQ-013 Access phase (penable=1 with pend=1) SHALL commit latched write and clear pend; psel, paddr, pwdata ignored in access phase.
REQ-014 penable=1 with pend=0 SHALL have no effect; back-to-back setup phases SHALL re-latch, last wins.
REQ-015 Read: prdata SHALL be loaded at the setup-phase edge and be valid throughout the following access cycle; writes SHALL leave prdata unchanged.
REQ-016 Register map: 0x00 CTRL RW {[15:8] PRESCALE, [2] IRQ_EN, [1] AUTO_RELOAD, [0] EN}; 0x04 LOAD RW; 0x08 COUNT RO; 0x0C STATUS {[0] EXPIRED, W1C}; 0x10 ID RO 32'hA7B0_0001.
REQ-017 Unmapped offsets and unused bits SHALL read 0; writes to them and to RO registers SHALL be ignored.
REQ-018 Prescaler SHALL count 0..PRESCALE while EN=1 and emit a one-cycle tick when equal to PRESCALE, then restart at 0; tick period = PRESCALE+1 cycles.
REQ-019 On tick: COUNT!=0 -> COUNT-1; COUNT==0 -> set EXPIRED, COUNT<=LOAD if AUTO_RELOAD else stays 0 and EN cleared (one-shot).
REQ-020 Expiry period SHALL be (LOAD+1)*(PRESCALE+1) cycles; LOAD=0 with AUTO_RELOAD expires every tick.
REQ-021 Write to LOAD SHALL also set COUNT=LOAD and clear the prescaler; write beats a same-cycle tick.
REQ-022 CTRL write changing EN 0->1 SHALL clear the prescaler; EN=0 SHALL freeze COUNT and prescaler.
REQ-023 STATUS W1C and same-cycle expiry: EXPIRED SHALL remain 1.
REQ-024 irq SHALL update the cycle after EXPIRED or IRQ_EN changes.

Reset
REQ-025 hreset SHALL asynchronously clear CTRL, LOAD, COUNT, EXPIRED, prescaler, pend, prdata and irq to 0.
REQ-026 Reset between setup and access SHALL discard the pending write; nothing commits after release.

Configuration
REQ-027 With APB_TIMER_PRESCALER_EN defined, REQ-018 applies and PRESCALE is RW.
REQ-028 Without APB_TIMER_PRESCALER_EN, tick SHALL be every cycle while EN=1, CTRL[15:8] SHALL read 0 and the prescaler SHALL not be instantiated.

Structure
REQ-029 Package apb_timer_pkg SHALL hold register offsets, CTRL/STATUS bit positions and the ID constant.
REQ-030 Sub-module apb_timer_prescaler SHALL implement the 8-bit prescaler (inputs en, clr, prescale; output tick).

Verification
REQ-031 Reset then read 0x10 -> prdata=32'hA7B0_0001 in access cycle; 0x00/0x04/0x08 read 0; irq=0.
REQ-032 LOAD=3, CTRL=0x05 (EN, IRQ_EN, PRESCALE=0) -> EXPIRED and irq after 4 ticks, EN reads 0, COUNT=0.
REQ-033 LOAD=2, CTRL=0x0203 (auto, PRESCALE=2, macro on) -> EXPIRED every 9 cycles, COUNT reloads 2.
REQ-034 Write 1 to 0x0C on expiry cycle -> EXPIRED stays 1; later write 1 -> EXPIRED=0, irq=0 next cycle.
REQ-035 Assert hreset between setup and access of LOAD=0x55 write -> LOAD reads 0 after reset.
REQ-036 Write 0x08 and 0x18 -> no register change, 0x18 reads 0.
